divider_param: RTL and testbench

- Parametrised iterative integer divider; next generation of the CPU's multi-cycle unsigned divide unit.
- Serves both DIV and DIVU. Operand width is generic. Adds divide-by-zero detection, a one-cycle done pulse, and restart-on-start.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy, then writes q/r into HI/LO.

---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider_if.sv | 24 ++
 rtl/divider_nr_step.sv | 19 +
 rtl/divider_param.sv | 114 +++++++++++
 tb/tb_divider_param.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative divider: FSM encoding and
// width-independent sign/magnitude helpers (callers truncate to their WIDTH).
package divider_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Callers pass a sign-extended operand so the MSB of word_t is the operand sign.
    function automatic word_t abs_val(input word_t x, input logic signed_en);
        return (signed_en && x[MAX_W-1]) ? -x : x;
    endfunction

    function automatic word_t neg_cond(input word_t x, input logic en);
        return en ? -x : x;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between the execute stage and the divider.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output a, b, is_signed, start,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  a, b, is_signed, start,
        output q, r, busy, done, div_zero
    );
endinterface

// File: rtl/divider_nr_step.sv
// One combinational non-restoring division step on a WIDTH+1 bit partial remainder.
module divider_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             q_msb,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_ext;

    // The dropped top bit is harmless: the result always lies in [-d, d) and fits.
    assign shifted  = {rem[WIDTH-1:0], q_msb};
    assign dvs_ext  = {1'b0, divisor};
    assign rem_next = rem[WIDTH] ? (shifted + dvs_ext) : (shifted - dvs_ext);
    assign q_bit    = ~rem_next[WIDTH];
endmodule

// File: rtl/divider_param.sv
// Iterative signed/unsigned divider (DIV/DIVU), one quotient bit per falling edge,
// with divide-by-zero flag, one-cycle done pulse and restart-on-start.
module divider_param
    import divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic      clock,
    input  logic      resetn,
    divider_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             dz_reg;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix, a_back;

    divider_nr_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (dvs),
        .q_msb    (dq[WIDTH-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign a_mag  = WIDTH'(abs_val(word_t'(signed'(bus.a)), bus.is_signed));
    assign b_mag  = WIDTH'(abs_val(word_t'(signed'(bus.b)), bus.is_signed));
    assign q_fix  = WIDTH'(neg_cond(word_t'(dq), neg_q));
    assign r_fix  = WIDTH'(neg_cond(word_t'(rem[WIDTH] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0]), neg_r));
    // On divide-by-zero dq still holds |a|; re-applying the dividend sign recovers a.
    assign a_back = WIDTH'(neg_cond(word_t'(dq), neg_r));

    always_ff @(negedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (resetn) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (bus.start) begin
            state_next = (bus.b == '0) ? FIX : RUN;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                RUN:     state_next = (cnt == LAST) ? FIX : RUN;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(negedge clock) begin
        if (resetn) begin
            rem    <= '0;
            dq     <= '0;
            dvs    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= 1'b0;
        end else if (bus.start) begin
            // Accepted from any state; an op in flight is dropped without touching q/r.
            rem    <= '0;
            dq     <= a_mag;
            dvs    <= b_mag;
            cnt    <= '0;
            neg_q  <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= bus.is_signed & bus.a[WIDTH-1];
            dz_reg <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    rem <= rem_next;
                    dq  <= {dq[WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (dvs == '0) begin
                        q_reg  <= '1;
                        r_reg  <= a_back;
                        dz_reg <= 1'b1;
                    end else begin
                        q_reg  <= q_fix;
                        r_reg  <= r_fix;
                        dz_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q        = q_reg;
    assign bus.r        = r_reg;
    assign bus.div_zero = dz_reg;
    assign bus.busy     = (state == RUN) || (state == FIX);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_divider_param.sv
// Directed self-checking bench for divider_param at WIDTH=32: vector table plus
// restart, mid-run reset and back-to-back sequences. Samples on the rising edge.
module tb_divider_param;
    localparam int W      = 32;
    localparam int BUDGET = 80;
    localparam int NV     = 13;

    logic clock;
    logic resetn;

    divider_if #(.WIDTH(W)) bus ();

    divider_param #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           done_at;
        int           busy_cyc;
    } vec_t;

    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request on the rising edge; it is accepted at the following falling edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        @(posedge clock);
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = sgn;
        bus.start     = 1'b1;
        @(negedge clock);
        #1 bus.start  = 1'b0;
    endtask

    // Counts rising edges after the accepting edge until done; done_at=0 means timeout.
    task automatic wait_done(output int done_at, output int busy_cyc);
        done_at  = 0;
        busy_cyc = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clock);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_at = c;
                break;
            end
        end
    endtask

    initial begin
        int done_at, busy_cyc, dones;
        logic [W-1:0] prev_q, prev_r;

        // a, b, signed, q, r, div_zero, done_at, busy cycles
        vecs[0]  = '{32'd100,      32'd7,          1'b0, 32'd14,         32'd2,          1'b0, W+2, W+1};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, W+2, W+1};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, W+2, W+1};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, W+2, W+1};
        vecs[4]  = '{32'hFFFFFFFF, 32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, W+2, W+1};
        vecs[5]  = '{32'd5,        32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1, 2,   1};
        vecs[6]  = '{32'd9,        32'd3,          1'b0, 32'd3,          32'd0,          1'b0, W+2, W+1};
        vecs[7]  = '{32'hFFFFFF9C, 32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, W+2, W+1};
        vecs[8]  = '{32'hFFFFFFFB, 32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 2,   1};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFE,   1'b0, 32'd1,          32'd1,          1'b0, W+2, W+1};
        vecs[10] = '{32'h80000000, 32'd3,          1'b0, 32'h2AAAAAAA,   32'd2,          1'b0, W+2, W+1};
        vecs[11] = '{32'd3,        32'd10,         1'b0, 32'd0,          32'd3,          1'b0, W+2, W+1};
        vecs[12] = '{32'hFFFFFFF9, 32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, W+2, W+1};

        bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.start = 1'b0;
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        #1 resetn = 1'b0;

        @(posedge clock);
        check("reset busy",     32'(bus.busy),     32'd0);
        check("reset done",     32'(bus.done),     32'd0);
        check("reset div_zero", 32'(bus.div_zero), 32'd0);
        check("reset q",        bus.q,             32'd0);
        check("reset r",        bus.r,             32'd0);

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sgn);
            wait_done(done_at, busy_cyc);
            check($sformatf("vec%0d done_at", i),  32'(done_at),      32'(vecs[i].done_at));
            check($sformatf("vec%0d busy_cyc", i), 32'(busy_cyc),     32'(vecs[i].busy_cyc));
            check($sformatf("vec%0d q", i),        bus.q,             vecs[i].q);
            check($sformatf("vec%0d r", i),        bus.r,             vecs[i].r);
            check($sformatf("vec%0d div_zero", i), 32'(bus.div_zero), 32'(vecs[i].dz));
            @(posedge clock);
            check($sformatf("vec%0d done pulse", i), 32'(bus.done),   32'd0);
        end

        // Restart: 100/7 aborted at iteration 10 by 50/5.
        prev_q = vecs[NV-1].q;
        prev_r = vecs[NV-1].r;
        dones  = 0;
        launch(32'd100, 32'd7, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            if (bus.done) dones++;
        end
        check("restart q held", bus.q, prev_q);
        check("restart r held", bus.r, prev_r);
        bus.a = 32'd50; bus.b = 32'd5; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(negedge clock);
        #1 bus.start = 1'b0;
        wait_done(done_at, busy_cyc);
        check("restart early done", 32'(dones),   32'd0);
        check("restart done_at",    32'(done_at), 32'(W + 2));
        check("restart q",          bus.q,        32'd10);
        check("restart r",          bus.r,        32'd0);

        // Back-to-back: new start presented during the DONE cycle.
        launch(32'd20, 32'd4, 1'b0);
        wait_done(done_at, busy_cyc);
        check("b2b first q", bus.q, 32'd5);
        check("b2b first r", bus.r, 32'd0);
        bus.a = 32'd21; bus.b = 32'd4; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(negedge clock);
        #1 bus.start = 1'b0;
        wait_done(done_at, busy_cyc);
        check("b2b second done_at", 32'(done_at),  32'(W + 2));
        check("b2b second busy",    32'(busy_cyc), 32'(W + 1));
        check("b2b second q",       bus.q,         32'd5);
        check("b2b second r",       bus.r,         32'd1);

        // Reset at iteration 20 aborts silently and clears results.
        launch(32'd100, 32'd7, 1'b0);
        repeat (20) @(posedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1 resetn = 1'b0;
        @(posedge clock);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset q",    bus.q,         32'd0);
        check("midreset r",    bus.r,         32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            if (bus.done || bus.busy) dones++;
        end
        check("midreset stays idle", 32'(dones), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
